// File: rtl/fc_mac_unit.sv
// Fully-connected MAC: LANES sign-magnitude products per beat,
// two's-complement accumulation, saturating sign-magnitude result.
module fc_mac_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_sat,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int MW = DATA_WIDTH - 1;
  localparam int PW = 2 * MW;

  generate
    if (ACC_WIDTH < PW + $clog2(LANES) + 1) begin : g_acc_chk
      $error("fc_mac_unit: ACC_WIDTH too small");
    end
  endgenerate

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic [PW-1:0] p_mag  [LANES];
  logic          p_sign [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      p_mag[i]  = PW'(in_a[i*DATA_WIDTH +: MW])
                * PW'(in_b[i*DATA_WIDTH +: MW]);
      p_sign[i] = (p_mag[i] != '0)
                && (in_a[i*DATA_WIDTH+MW] ^ in_b[i*DATA_WIDTH+MW]);
    end
  end

  logic [PW-1:0] s1_mag  [LANES];
  logic          s1_sign [LANES];
  logic          s1_valid;
  logic          s1_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_mag[i]  <= '0;
        s1_sign[i] <= 1'b0;
      end
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_last  <= in_last;
      for (int i = 0; i < LANES; i++) begin
        s1_mag[i]  <= p_mag[i];
        s1_sign[i] <= p_sign[i];
      end
    end
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] lane_sum;
  logic [ACC_WIDTH-1:0] total;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_sign[i])
        lane_sum = lane_sum - ACC_WIDTH'(s1_mag[i]);
      else
        lane_sum = lane_sum + ACC_WIDTH'(s1_mag[i]);
    end
    total = acc + lane_sum;
  end

  localparam logic [ACC_WIDTH-1:0] MAX_MAG = ACC_WIDTH'({MW{1'b1}});

  logic                 neg;
  logic [ACC_WIDTH-1:0] abs_sum;
  logic [ACC_WIDTH-1:0] mag_full;
  logic                 res_sat;
  logic [MW-1:0]        res_mag;
  logic                 res_sign;

  // Truncate toward zero on the magnitude so -0 never appears.
  always_comb begin
    neg      = total[ACC_WIDTH-1];
    abs_sum  = neg ? -total : total;
    mag_full = abs_sum >> FRAC_BITS;
    res_sat  = mag_full > MAX_MAG;
    res_mag  = res_sat ? {MW{1'b1}} : mag_full[MW-1:0];
    res_sign = neg && (res_mag != '0);
  end

  logic step;
  logic load;
  assign step = s1_valid && !stall;
  assign load = step && s1_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (step)
        acc <= s1_last ? '0 : total;
      if (load) begin
        out_data  <= {res_sign, res_mag};
        out_sat   <= res_sat;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_mac_unit.sv
// Bench for fc_mac_unit: directed cases plus random dot products
// checked against an integer reference model.
module tb_fc_mac_unit;

  logic        clk;
  logic        rst;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;

  fc_mac_unit #(
    .DATA_WIDTH(16),
    .LANES(4),
    .FRAC_BITS(8),
    .ACC_WIDTH(40)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_a(in_a),
    .in_b(in_b),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_sat(out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  longint      acc_m;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  logic        accepted;
  logic        rand_ready;

  // Value of one beat: signed sum of lane products, in raw fixed point.
  function automatic longint beat_val(input logic [63:0] a,
                                      input logic [63:0] b);
    longint s, ma, mb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      ma = a[i*16 +: 15];
      mb = b[i*16 +: 15];
      if (a[i*16+15] ^ b[i*16+15]) s = s - ma * mb;
      else s = s + ma * mb;
    end
    return s;
  endfunction

  function automatic logic [16:0] to_res(input longint s);
    longint m;
    logic   sat;
    m = (s < 0) ? -s : s;
    m = m / 256;
    sat = (m > 32767);
    if (sat) m = 32767;
    return {sat, (s < 0) && (m != 0), m[14:0]};
  endfunction

  task automatic tick();
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    accepted = in_valid && in_ready && !rst;
    if (rst) begin
      acc_m = 0;
    end else begin
      if (accepted) begin
        acc_m += beat_val(in_a, in_b);
        if (in_last) begin
          exp_q.push_back(to_res(acc_m));
          acc_m = 0;
        end
      end
      if (out_valid && out_ready)
        got_q.push_back({out_sat, out_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic last);
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) begin
      miscompares++;
      $display("FAIL send_timeout: beat not accepted, got 0 need 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic flush();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({out_valid, out_sat, out_data} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b s=%b d=%h need 0/0/0000",
               out_valid, out_sat, out_data);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_a = 64'h0100;
    in_b = 64'h0200;
    in_last = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (accepted !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_edge1: got acc=%b v=%b need 1/0",
               accepted, out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h0200 || out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_edge2: got v=%b d=%h s=%b need 1/0200/0",
               out_valid, out_data, out_sat);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_clear: got v=%b need 0", out_valid);
    end
    flush();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_sign();
    send(64'h8100, 64'h0300, 1'b0);
    send(64'h0100_0000, 64'h0100_0000, 1'b1);
    flush();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 17'h08200) begin
      miscompares++;
      $display("FAIL sign_sum: got n=%0d r=%h need 1/08200",
               got_q.size(), got_q[0]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_neg_zero();
    send(64'h8000, 64'h8123, 1'b1);
    flush();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 17'h00000) begin
      miscompares++;
      $display("FAIL neg_zero: got n=%0d r=%h need 1/00000",
               got_q.size(), got_q[0]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_saturation();
    send({4{16'h7FFF}}, {4{16'h7FFF}}, 1'b1);
    send({4{16'hFFFF}}, {4{16'h7FFF}}, 1'b1);
    flush();
    vectors++;
    if (got_q.size() != 2 || got_q[0] !== 17'h17FFF
        || got_q[1] !== 17'h1FFFF) begin
      miscompares++;
      $display("FAIL saturation: got n=%0d r0=%h r1=%h need 2/17fff/1ffff",
               got_q.size(), got_q[0], got_q[1]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(64'h0100, 64'h0100, 1'b1);
    send(64'h0200, 64'h0300, 1'b1);
    in_a = 64'h8100;
    in_b = 64'h0100;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (in_ready !== 1'b0 || accepted !== 1'b0 || out_valid !== 1'b1
          || out_data !== 16'h0100) begin
        miscompares++;
        $display("FAIL stall_hold: got rdy=%b acc=%b v=%b d=%h need 0/0/1/0100",
                 in_ready, accepted, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (accepted !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'h0600) begin
      miscompares++;
      $display("FAIL release_b: got acc=%b v=%b d=%h need 1/1/0600",
               accepted, out_valid, out_data);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 16'h8100) begin
      miscompares++;
      $display("FAIL release_c: got v=%b d=%h need 1/8100", out_valid, out_data);
    end
    flush();
    vectors++;
    if (got_q.size() != 3 || got_q[0] !== 17'h00100
        || got_q[1] !== 17'h00600 || got_q[2] !== 17'h08100) begin
      miscompares++;
      $display("FAIL b2b_order: got n=%0d %h %h %h need 3 00100 00600 08100",
               got_q.size(), got_q[0], got_q[1], got_q[2]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_state: got v=%b rdy=%b need 0/1",
               out_valid, in_ready);
    end
    send(64'h0100, 64'h0100, 1'b1);
    flush();
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== 17'h00100) begin
      miscompares++;
      $display("FAIL reset_mid_result: got n=%0d r=%h need 1/00100",
               got_q.size(), got_q[0]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic logic [63:0] rand_ops();
    logic [63:0] v;
    v = {$urandom, $urandom};
    for (int i = 0; i < 4; i++)
      if ($urandom_range(0, 7) == 0) v[i*16 +: 15] = '0;
    return v;
  endfunction

  task automatic test_random();
    int n;
    rand_ready = 1'b1;
    for (int p = 0; p < 150; p++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send(rand_ops(), rand_ops(), k == n - 1);
      end
    end
    flush();
    vectors++;
    if (got_q.size() != exp_q.size() || exp_q.size() != 150) begin
      miscompares++;
      $display("FAIL random_count: got %0d results need %0d (150 sent)",
               got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random_result[%0d]: got %h need %h",
                 i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_a = '0;
    in_b = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    rand_ready = 1'b0;
    acc_m = 0;
    accepted = 1'b0;
    #2;
    test_reset();
    test_latency();
    test_sign();
    test_neg_zero();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
